// File: rtl/adder_seq_nbit_pkg.sv
// Shared ALU package: FSM state encoding and add/sub opcode constants.
// Used by adder_seq_nbit and its testbench.
package sap_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_seq_nbit_if.sv
// Operand/result handshake bundle for adder_seq_nbit.
// zero/ovf exist only when ADDSUB_FLAGS_EN is defined.
interface adder_seq_nbit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDSUB_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
`ifdef ADDSUB_FLAGS_EN
        input  zero, ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
`ifdef ADDSUB_FLAGS_EN
        output zero, ovf,
`endif
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/adder_seq_nbit_slice.sv
// CHUNK-bit combinational ripple adder used for one slice per cycle.
// cmsb is the carry into the slice MSB (for overflow detection).
module adder_ripple_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/adder_seq_nbit.sv
// Sequential add/sub: WIDTH bits processed CHUNK bits per cycle.
// Define ADDSUB_FLAGS_EN to add the zero/ovf result flags.
module adder_seq_nbit
    import sap_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input logic            clk,
    input logic            rst,
    adder_seq_nbit_if.slave bus
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] s_sum;
    logic             s_cout;
    logic             s_cmsb;
    logic             accept;
    logic             busy;
    logic             last;

    assign accept = (state == IDLE) && bus.in_valid;
    assign busy   = (state == BUSY);
    assign last   = (cnt == CW'(N - 1));

    adder_ripple_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a   (a_q[CHUNK-1:0]),
        .b   (b_q[CHUNK-1:0]),
        .cin (carry),
        .sum (s_sum),
        .cout(s_cout),
        .cmsb(s_cmsb)
    );

    // Completed slices collect in acc; res is the full word on the last slice.
    generate
        if (N == 1) begin : g_one
            assign res = s_sum;
        end else begin : g_multi
            logic [WIDTH-CHUNK-1:0] acc;
            assign res = {s_sum, acc};
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc <= '0;
                end else if (busy) begin
                    acc <= res[WIDTH-1:CHUNK];
                end
            end
        end
    endgenerate

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nx = BUSY;
            BUSY:    if (last)          state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= (bus.sub == OP_ADD) ? bus.b : ~bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (busy) begin
            a_q   <= a_q >> CHUNK;
            b_q   <= b_q >> CHUNK;
            carry <= s_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum_q  <= res;
                cout_q <= s_cout;
            end
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic zero_q;
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (busy && last) begin
            zero_q <= (res == '0);
            ovf_q  <= s_cmsb ^ s_cout;
        end
    end

    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = s_cmsb;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// Bench for adder_seq_nbit: 8/4 and 4/4 instances, directed vectors.
// Flag checks are compiled in only with ADDSUB_FLAGS_EN.
module tb_adder_seq_nbit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    adder_seq_nbit_if #(.WIDTH(8)) i8 ();
    adder_seq_nbit_if #(.WIDTH(4)) i4 ();

    adder_seq_nbit #(.WIDTH(8), .CHUNK(4)) u8 (
        .clk(clk),
        .rst(rst),
        .bus(i8.slave)
    );

    adder_seq_nbit #(.WIDTH(4), .CHUNK(4)) u4 (
        .clk(clk),
        .rst(rst),
        .bus(i4.slave)
    );

    // Model expectations for the operation currently in flight.
    logic [7:0] e8_sum;
    logic       e8_cout, e8_zero, e8_ovf;
    logic [3:0] e4_sum;
    logic       e4_cout, e4_zero, e4_ovf;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && i8.out_valid === 1'b1) begin
            chk("m8_sum", {24'd0, i8.sum}, {24'd0, e8_sum});
            chk("m8_cout", {31'd0, i8.cout}, {31'd0, e8_cout});
`ifdef ADDSUB_FLAGS_EN
            chk("m8_zero", {31'd0, i8.zero}, {31'd0, e8_zero});
            chk("m8_ovf", {31'd0, i8.ovf}, {31'd0, e8_ovf});
`endif
        end
        if (rst === 1'b0 && i4.out_valid === 1'b1) begin
            chk("m4_sum", {28'd0, i4.sum}, {28'd0, e4_sum});
            chk("m4_cout", {31'd0, i4.cout}, {31'd0, e4_cout});
`ifdef ADDSUB_FLAGS_EN
            chk("m4_zero", {31'd0, i4.zero}, {31'd0, e4_zero});
            chk("m4_ovf", {31'd0, i4.ovf}, {31'd0, e4_ovf});
`endif
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic s, input int hold,
                        input logic [7:0] xs, input logic xc,
                        input logic xz, input logic xo);
        logic [7:0] bb;
        logic [8:0] f;
        int         lat;
        bb      = s ? ~b : b;
        f       = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
        e8_sum  = f[7:0];
        e8_cout = f[8];
        e8_zero = (f[7:0] == 8'd0);
        e8_ovf  = (a[7] == bb[7]) && (f[7] != a[7]);
        chk("idle_in_ready", {31'd0, i8.in_ready}, 32'd1);
        i8.a        = a;
        i8.b        = b;
        i8.cin      = ci;
        i8.sub      = s;
        i8.in_valid = 1'b1;
        @(negedge clk);
        i8.in_valid = 1'b0;
        i8.a        = ~a;
        i8.b        = ~b;
        lat = 0;
        while (i8.out_valid !== 1'b1 && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk("latency8", lat, 32'd2);
        chk("lit_sum8", {24'd0, i8.sum}, {24'd0, xs});
        chk("lit_cout8", {31'd0, i8.cout}, {31'd0, xc});
`ifdef ADDSUB_FLAGS_EN
        chk("lit_zero8", {31'd0, i8.zero}, {31'd0, xz});
        chk("lit_ovf8", {31'd0, i8.ovf}, {31'd0, xo});
`else
        if (xz === 1'bx || xo === 1'bx) chk("lit_flags_arg", 32'd0, 32'd1);
`endif
        for (int i = 0; i < hold; i++) begin
            chk("hold_in_ready", {31'd0, i8.in_ready}, 32'd0);
            chk("hold_sum", {24'd0, i8.sum}, {24'd0, xs});
            chk("hold_cout", {31'd0, i8.cout}, {31'd0, xc});
            i8.in_valid = i[0] ? 1'b0 : 1'b1;
            i8.a        = 8'h55 + 8'(i);
            @(negedge clk);
        end
        i8.out_ready = 1'b1;
        i8.in_valid  = 1'b1;
        @(negedge clk);
        i8.out_ready = 1'b0;
        i8.in_valid  = 1'b0;
        chk("release_out_valid", {31'd0, i8.out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, i8.in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        i8.in_valid = 1'b0; i8.a = '0; i8.b = '0;
        i8.cin = 1'b0; i8.sub = 1'b0; i8.out_ready = 1'b0;
        i4.in_valid = 1'b0; i4.a = '0; i4.b = '0;
        i4.cin = 1'b0; i4.sub = 1'b0; i4.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_sum8", {24'd0, i8.sum}, 32'd0);
        chk("rst_cout8", {31'd0, i8.cout}, 32'd0);
        chk("rst_in_ready8", {31'd0, i8.in_ready}, 32'd1);
        chk("rst_out_valid8", {31'd0, i8.out_valid}, 32'd0);
        chk("rst_in_ready4", {31'd0, i4.in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run8(8'hFF, 8'h00, 1'b0, 1'b0, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
        run8(8'h00, 8'hFF, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b0, 1'b1);
        run8(8'h05, 8'h07, 1'b1, 1'b1, 5, 8'hFE, 1'b0, 1'b0, 1'b0);
        run8(8'h07, 8'h05, 1'b1, 1'b1, 0, 8'h02, 1'b1, 1'b0, 1'b0);
        run8(8'hA5, 8'h5A, 1'b1, 1'b0, 2, 8'h00, 1'b1, 1'b1, 1'b0);
        run8(8'h80, 8'h01, 1'b1, 1'b1, 0, 8'h7F, 1'b1, 1'b0, 1'b1);

        // Abort in the first BUSY cycle.
        i8.a = 8'h12; i8.b = 8'h34; i8.cin = 1'b0; i8.sub = 1'b0;
        i8.in_valid = 1'b1;
        @(negedge clk);
        i8.in_valid = 1'b0;
        chk("abort_busy", {31'd0, i8.in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", {31'd0, i8.in_ready}, 32'd1);
        chk("abort_sum", {24'd0, i8.sum}, 32'd0);
        chk("abort_cout", {31'd0, i8.cout}, 32'd0);
`ifdef ADDSUB_FLAGS_EN
        chk("abort_zero", {31'd0, i8.zero}, 32'd0);
        chk("abort_ovf", {31'd0, i8.ovf}, 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_valid", {31'd0, i8.out_valid}, 32'd0);
            @(negedge clk);
        end
        run8(8'h01, 8'h01, 1'b1, 1'b0, 0, 8'h03, 1'b0, 1'b0, 1'b0);

        // Single-slice instance.
        e4_sum = 4'h0; e4_cout = 1'b1; e4_zero = 1'b1; e4_ovf = 1'b0;
        i4.a = 4'hF; i4.b = 4'h1; i4.cin = 1'b0; i4.sub = 1'b0;
        i4.in_valid = 1'b1;
        @(negedge clk);
        i4.in_valid = 1'b0;
        lat = 0;
        while (i4.out_valid !== 1'b1 && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk("latency4", lat, 32'd1);
        chk("lit_sum4", {28'd0, i4.sum}, 32'd0);
        chk("lit_cout4", {31'd0, i4.cout}, 32'd1);
        i4.out_ready = 1'b1;
        @(negedge clk);
        i4.out_ready = 1'b0;
        chk("release4", {31'd0, i4.in_ready}, 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
